truth_table_sweeper: RTL
========================

// Module: truth_table_sweeper
// PURPOSE
//  Parametrised in-circuit exhaustive tester for small combinational blocks.
//  - Drives every N_IN-bit input vector (0 .. 2^N_IN-1) onto the DUT in turn.
//  - Holds each vector HOLD_CYCLES clocks, then samples the N_OUT-bit response.
//  - Checks each response against a packed expected truth table.
//  - Reports the error count, the first failing vector and pass/done status.
//  Sits between a lab combinational block and board LEDs/switches.
// PARAMETERS
//  N_IN        3        DUT input width; the sweep covers 2^N_IN vectors
//  N_OUT       2        DUT output width
//  HOLD_CYCLES 4        clocks each vector is held before sampling; must be >= 1
//  EXP_TABLE   16'hE994 expected table, N_OUT*2^N_IN bits; vector i at [i*N_OUT +: N_OUT]
//                       default = full adder, stim={a,b,c}, resp={carry,sum}
// PORTS
//  clk            in   1          single clock, rising edge
//  rst_n          in   1          synchronous reset, active low
//  start          in   1          begin sweep; sampled only in IDLE or DONE
//  abort          in   1          cancel sweep; higher priority than start
//  stim           out  N_IN       vector driven to DUT inputs
//  resp           in   N_OUT      DUT outputs, treated as combinational from stim
//  busy           out  1          high in APPLY/SAMPLE
//  done           out  1          high in DONE, held until next start/abort/reset
//  pass           out  1          valid when done; 1 iff err_count==0
//  err_count      out  N_IN+1     number of mismatching vectors, range 0..2^N_IN
//  first_fail     out  N_IN       index of first mismatching vector
//  fail_seen      out  1          first_fail is valid
// BEHAVIOUR
//  - Reset (rst_n==0 at posedge, any state):
//    - state=IDLE.
//    - stim, busy, done, pass, err_count, first_fail, fail_seen, hold_cnt all 0.
//  - IDLE/DONE + start (abort=0): next state APPLY.
//    - stim=0, hold_cnt=0, err_count=0, fail_seen=0, first_fail=0.
//    - done=0, pass=0, busy=1.
//  - APPLY: hold_cnt increments each clock.
//    - Go to SAMPLE when hold_cnt==HOLD_CYCLES-1.
//    - stim stays stable for the whole APPLY+SAMPLE window.
//  - SAMPLE (one clock):
//    - Compare resp with EXP_TABLE[stim*N_OUT +: N_OUT].
//    - On mismatch: err_count+1; if fail_seen==0, set first_fail=stim and fail_seen=1.
//    - If stim==2^N_IN-1: go to DONE; done=1, busy=0.
//      pass = (err_count after this compare)==0.
//    - Otherwise: stim+1, hold_cnt=0, go to APPLY.
//  - Latency: done rises 2^N_IN*(HOLD_CYCLES+1) clocks after the edge that accepts start.
//    Default: 8*5 = 40.
//  - start while busy: ignored. start in DONE: restarts cleanly.
//  - abort in any state: next state IDLE, stim=0, busy=0, done=0, pass=0.
//    err_count, first_fail and fail_seen keep their values for debug.
//  - abort and start in the same cycle: abort wins.
//  - stim never wraps: the terminal vector always ends in DONE.
//  - err_count is N_IN+1 bits, so it cannot overflow.
//  - Reset mid-sweep: identical to reset from IDLE; no partial results survive.
//  - All outputs are registered; resp is the only combinational input path.
// STRUCTURE
//  - Shared package truth_sweep_pkg:
//    - state encoding localparams IDLE=2'd0, APPLY=2'd1, SAMPLE=2'd2, DONE=2'd3.
//    - localparam function for table width N_OUT<<N_IN.
//  - One sub-module, sweep_hold_timer (parameter HOLD_CYCLES).
//    - Inputs: clear, enable. Output: expire, high when the count reaches HOLD_CYCLES-1.
//    - The top level holds the FSM, vector counter, comparator and result registers.
// TESTING
//  1. Default params, correct full-adder DUT, pulse start:
//     -> done=1 at 40 clocks, pass=1, err_count=0, fail_seen=0; stim steps 0..7 every 5 clocks.
//  2. Full adder with sum stuck at 0:
//     -> err_count=4, first_fail=1, fail_seen=1, pass=0.
//  3. Start, then abort at clock 12:
//     -> next clock busy=0, done=0, stim=0; later start reruns the full 40-clock sweep.
//  4. rst_n=0 for one clock at clock 20 of a sweep:
//     -> all outputs 0, state IDLE; start pulses during the sweep are ignored.
//  5. Params N_IN=4, N_OUT=1, HOLD_CYCLES=1, EXP_TABLE=16'h6996 (4-bit parity), parity DUT:
//     -> done at 32 clocks, pass=1.
//  6. Start and abort asserted together in DONE:
//     -> IDLE, done=0, no sweep begins.

Source files
------------

// File: rtl/truth_sweep_pkg.sv
// Shared definitions for the truth-table sweeper: FSM encoding and table sizing.
package truth_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Packed expected-table width: one N_OUT-bit entry per input vector.
  function automatic int table_w(input int n_in, input int n_out);
    return n_out << n_in;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Control, status and DUT-facing signals of the sweeper; slave is the sweeper side.
interface truth_table_sweeper_if #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 2
);
  logic             start;
  logic             abort;
  logic [N_IN-1:0]  stim;
  logic [N_OUT-1:0] resp;
  logic             busy;
  logic             done;
  logic             pass;
  logic [N_IN:0]    err_count;
  logic [N_IN-1:0]  first_fail;
  logic             fail_seen;

  modport master (
    output start, abort, resp,
    input  stim, busy, done, pass, err_count, first_fail, fail_seen
  );

  modport slave (
    input  start, abort, resp,
    output stim, busy, done, pass, err_count, first_fail, fail_seen
  );
endinterface

// File: rtl/sweep_hold_timer.sv
// Counts clocks a vector has been held; expire flags the last hold clock.
module sweep_hold_timer #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic [CW-1:0] hold_cnt;

  assign expire = (hold_cnt == CW'(HOLD_CYCLES - 1));

  // Stop at the terminal count; the FSM leaves APPLY on that same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (clear) begin
      hold_cnt <= '0;
    end else if (enable && !expire) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive in-circuit tester: steps every input vector, holds it, compares the response.
module truth_table_sweeper
  import truth_sweep_pkg::*;
#(
  parameter int N_IN        = 3,
  parameter int N_OUT       = 2,
  parameter int HOLD_CYCLES = 4,
  parameter logic [table_w(N_IN, N_OUT)-1:0] EXP_TABLE = 16'hE994
) (
  input logic                 clk,
  input logic                 rst_n,
  truth_table_sweeper_if.slave bus
);
  localparam logic [N_IN-1:0] LAST_VEC = '1;

  state_t           state_q, state_d;
  logic [N_IN-1:0]  stim_q, stim_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [N_IN:0]    err_q, err_d;
  logic [N_IN-1:0]  first_q, first_d;
  logic             seen_q, seen_d;
  logic             tmr_clear, tmr_en, expire;
  logic [N_OUT-1:0] exp_resp;
  logic             mismatch;

  sweep_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tmr_clear),
    .enable (tmr_en),
    .expire (expire)
  );

  assign exp_resp = EXP_TABLE[stim_q * N_OUT +: N_OUT];
  assign mismatch = (bus.resp != exp_resp);

  always_comb begin
    state_d   = state_q;
    stim_d    = stim_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    err_d     = err_q;
    first_d   = first_q;
    seen_d    = seen_q;
    tmr_clear = 1'b0;
    tmr_en    = 1'b0;
    // Abort leaves error results in place so a cancelled run can still be inspected.
    if (bus.abort) begin
      state_d   = IDLE;
      stim_d    = '0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      pass_d    = 1'b0;
      tmr_clear = 1'b1;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          tmr_clear = 1'b1;
          if (bus.start) begin
            state_d = APPLY;
            stim_d  = '0;
            err_d   = '0;
            first_d = '0;
            seen_d  = 1'b0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
            busy_d  = 1'b1;
          end
        end
        APPLY: begin
          tmr_en = 1'b1;
          if (expire) state_d = SAMPLE;
        end
        SAMPLE: begin
          tmr_clear = 1'b1;
          err_d     = err_q + {{N_IN{1'b0}}, mismatch};
          if (mismatch && !seen_q) begin
            first_d = stim_q;
            seen_d  = 1'b1;
          end
          if (stim_q == LAST_VEC) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            pass_d  = (err_d == '0);
          end else begin
            state_d = APPLY;
            stim_d  = stim_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      stim_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      first_q <= '0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      first_q <= first_d;
      seen_q  <= seen_d;
    end
  end

  assign bus.stim       = stim_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_count  = err_q;
  assign bus.first_fail = first_q;
  assign bus.fail_seen  = seen_q;
endmodule
